// File: rtl/ifetch.sv
// Instruction fetch unit for the cirno9 core.
// Issues sequential word fetches and buffers the in-order responses in a small
// FIFO. A shared credit budget (outstanding requests plus buffered entries)
// guarantees the FIFO cannot overflow. Redirects flush the FIFO and arm a kill
// counter so stale responses still in flight are discarded.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_ibus_req_valid,
    input  logic        i_ibus_req_ready,
    output logic [31:0] o_ibus_req_addr,
    input  logic        i_ibus_rsp_valid,
    input  logic [31:0] i_ibus_rsp_data,
    input  logic        i_ibus_rsp_err,
    output logic        o_ibus_rsp_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_ir_valid,
    input  logic        i_ir_ready,
    output logic [31:0] o_ir_instr,
    output logic [31:0] o_ir_pc,
    output logic        o_ir_err
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned SumW = CntW + 1;

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     rsp_pc_q, rsp_pc_d;
    logic [CntW-1:0] outst_q, outst_d;
    logic [CntW-1:0] kill_q, kill_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0] mem_instr [DEPTH];
    logic [31:0] mem_pc    [DEPTH];
    logic        mem_err   [DEPTH];

    logic            pop;
    logic            req_hs;
    logic [SumW-1:0] used;
    logic            push;
    logic [31:0]     push_instr;
    logic [31:0]     push_pc;
    logic            push_err;
    logic [PtrW-1:0] wr_idx;

    // Handshakes and credit-limited request issue; outputs held quiet in reset.
    always_comb begin
        o_ir_valid       = (count_q != '0);
        pop              = o_ir_valid & i_ir_ready;
        used             = SumW'(outst_q) + SumW'(count_q) - SumW'(pop);
        o_ibus_req_valid = i_rst_n & (state_q == StRun) & ~i_redirect & (used < SumW'(DEPTH));
        o_ibus_req_addr  = fetch_pc_q;
        req_hs           = o_ibus_req_valid & i_ibus_req_ready;
        o_ibus_rsp_ready = 1'b1;
        o_ir_instr       = o_ir_valid ? mem_instr[rd_ptr_q] : 32'h0;
        o_ir_pc          = o_ir_valid ? mem_pc[rd_ptr_q]    : 32'h0;
        o_ir_err         = o_ir_valid ? mem_err[rd_ptr_q]   : 1'b0;
    end

    // Next-state: PC tracking, kill bookkeeping, redirect and bus-error handling.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        kill_d     = kill_q;
        push       = 1'b0;
        push_instr = 32'h0;
        push_pc    = rsp_pc_q;
        push_err   = 1'b0;
        outst_d    = outst_q + CntW'(req_hs) - CntW'(i_ibus_rsp_valid);

        if (req_hs) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (i_redirect) begin
            // Everything still outstanding after this cycle is stale; a response
            // arriving right now is simply never pushed.
            kill_d = outst_d;
            if (i_redirect_pc[1:0] == 2'b00) begin
                fetch_pc_d = i_redirect_pc;
                rsp_pc_d   = i_redirect_pc;
                state_d    = StRun;
            end else begin
                push     = 1'b1;
                push_pc  = i_redirect_pc;
                push_err = 1'b1;
                state_d  = StHalt;
            end
        end else if (i_ibus_rsp_valid) begin
            if (kill_q != '0) begin
                kill_d = kill_q - CntW'(1);
            end else if (!i_ibus_rsp_err) begin
                push       = 1'b1;
                push_instr = i_ibus_rsp_data;
                rsp_pc_d   = rsp_pc_q + 32'd4;
            end else begin
                push     = 1'b1;
                push_err = 1'b1;
                state_d  = StHalt;
                kill_d   = outst_d;
            end
        end
    end

    // FIFO pointer/occupancy update; a redirect restarts the FIFO at slot 0.
    always_comb begin
        if (i_redirect) begin
            wr_idx   = '0;
            rd_ptr_d = '0;
            wr_ptr_d = push ? PtrW'(1) : '0;
            count_d  = push ? CntW'(1) : '0;
        end else begin
            wr_idx   = wr_ptr_q;
            rd_ptr_d = rd_ptr_q + PtrW'(pop);
            wr_ptr_d = wr_ptr_q + PtrW'(push);
            count_d  = count_q + CntW'(push) - CntW'(pop);
        end
    end

    // Fetch state and all control registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StRun;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            kill_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            kill_q     <= kill_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // FIFO storage; contents are only observed through the valid-gated outputs.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_instr[wr_idx] <= push_instr;
            mem_pc[wr_idx]    <= push_pc;
            mem_err[wr_idx]   <= push_err;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: a cycle table for streaming, redirects,
// misaligned targets and bus errors, then a modelled 3-cycle bus with decode
// backpressure, then an asynchronous reset in the middle of traffic.
module tb_ifetch;

    localparam logic [31:0] B = 32'h8000_0000;
    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        i_rst_n;
    logic        o_ibus_req_valid;
    logic        i_ibus_req_ready;
    logic [31:0] o_ibus_req_addr;
    logic        i_ibus_rsp_valid;
    logic [31:0] i_ibus_rsp_data;
    logic        i_ibus_rsp_err;
    logic        o_ibus_rsp_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_ir_valid;
    logic        i_ir_ready;
    logic [31:0] o_ir_instr;
    logic [31:0] o_ir_pc;
    logic        o_ir_err;

    ifetch #(.RESET_PC(B), .DEPTH(DEPTH)) dut (
        .i_clk           (clk),
        .i_rst_n         (i_rst_n),
        .o_ibus_req_valid(o_ibus_req_valid),
        .i_ibus_req_ready(i_ibus_req_ready),
        .o_ibus_req_addr (o_ibus_req_addr),
        .i_ibus_rsp_valid(i_ibus_rsp_valid),
        .i_ibus_rsp_data (i_ibus_rsp_data),
        .i_ibus_rsp_err  (i_ibus_rsp_err),
        .o_ibus_rsp_ready(o_ibus_rsp_ready),
        .i_redirect      (i_redirect),
        .i_redirect_pc   (i_redirect_pc),
        .o_ir_valid      (o_ir_valid),
        .i_ir_ready      (i_ir_ready),
        .o_ir_instr      (o_ir_instr),
        .o_ir_pc         (o_ir_pc),
        .o_ir_err        (o_ir_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One table row = one clock cycle of inputs and the outputs expected in it.
    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rsp_v;
        logic [31:0] rdata;
        logic        rerr;
        logic        irdy;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_iv;
        logic [31:0] e_ii;
        logic [31:0] e_ip;
        logic        e_ie;
    } vec_t;

    function automatic vec_t mk(input logic redir, input logic [31:0] rpc, input logic rsp_v,
                                input logic [31:0] rdata, input logic rerr, input logic irdy,
                                input logic e_rv, input logic [31:0] e_ra, input logic e_iv,
                                input logic [31:0] e_ii, input logic [31:0] e_ip,
                                input logic e_ie);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.rsp_v = rsp_v; v.rdata = rdata; v.rerr = rerr;
        v.irdy = irdy; v.e_rv = e_rv; v.e_ra = e_ra; v.e_iv = e_iv; v.e_ii = e_ii;
        v.e_ip = e_ip; v.e_ie = e_ie;
        return v;
    endfunction

    // Modelled bus with fixed response latency.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    int          cyc;
    int          issued;
    int          popped;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    logic        stalled_prev;
    logic [31:0] prev_instr;
    logic [31:0] prev_pc;
    logic        prev_err;

    task automatic check_reset_values(input string tag);
        chk({tag, "_req_valid"}, {31'b0, o_ibus_req_valid}, 32'd0);
        chk({tag, "_req_addr"}, o_ibus_req_addr, B);
        chk({tag, "_ir_valid"}, {31'b0, o_ir_valid}, 32'd0);
        chk({tag, "_ir_instr"}, o_ir_instr, 32'h0);
        chk({tag, "_ir_pc"}, o_ir_pc, 32'h0);
        chk({tag, "_ir_err"}, {31'b0, o_ir_err}, 32'd0);
        chk({tag, "_rsp_ready"}, {31'b0, o_ibus_rsp_ready}, 32'd1);
    endtask

    // Called at a negedge; runs one cycle of the bus model and returns at the next negedge.
    task automatic bus_step(input logic rdy, input int lat);
        pend_t p;
        i_redirect       = 1'b0;
        i_ibus_req_ready = 1'b1;
        i_ir_ready       = rdy;
        i_ibus_rsp_err   = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            i_ibus_rsp_valid = 1'b1;
            i_ibus_rsp_data  = ~p.addr;
        end else begin
            i_ibus_rsp_valid = 1'b0;
            i_ibus_rsp_data  = 32'h0;
        end
        #2;
        if (stalled_prev) begin
            chk($sformatf("stall_hold_c%0d", cyc),
                {31'b0, o_ir_valid} ^ o_ir_instr ^ o_ir_pc ^ {31'b0, o_ir_err} ^
                (o_ir_instr ^ prev_instr) ^ (o_ir_pc ^ prev_pc),
                {31'b0, 1'b1} ^ prev_instr ^ prev_pc ^ {31'b0, prev_err});
            chk($sformatf("stall_pc_c%0d", cyc), o_ir_pc, prev_pc);
        end
        if (o_ir_valid && rdy) begin
            chk($sformatf("bp_pc_c%0d", cyc), o_ir_pc, exp_pc);
            chk($sformatf("bp_instr_c%0d", cyc), o_ir_instr, ~exp_pc);
            exp_pc = exp_pc + 32'd4;
            popped++;
        end
        stalled_prev = o_ir_valid && !rdy;
        prev_instr   = o_ir_instr;
        prev_pc      = o_ir_pc;
        prev_err     = o_ir_err;
        if (o_ibus_req_valid) begin
            chk($sformatf("bp_req_addr_c%0d", cyc), o_ibus_req_addr, exp_req);
            exp_req = exp_req + 32'd4;
            pend.push_back('{o_ibus_req_addr, cyc + lat});
            issued++;
        end
        if (issued - popped > int'(DEPTH)) begin
            checks++;
            errors++;
            $display("FAIL bp_credit_c%0d: in use %0d limit %0d", cyc, issued - popped, DEPTH);
        end else begin
            checks++;
        end
        cyc++;
        @(negedge clk);
    endtask

    vec_t vecs[$];

    initial begin
        i_rst_n          = 1'b0;
        i_ibus_req_ready = 1'b1;
        i_ibus_rsp_valid = 1'b0;
        i_ibus_rsp_data  = 32'h0;
        i_ibus_rsp_err   = 1'b0;
        i_redirect       = 1'b0;
        i_redirect_pc    = 32'h0;
        i_ir_ready       = 1'b1;

        //                   redir rpc        rv data          er rdy  erv era        eiv eii           eip       eie
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,        0, 1, 1, B+32'h000, 0, 32'h0,        32'h0,     0));
        vecs.push_back(mk(0, 32'h0,    1, 32'h11111111, 0, 1, 1, B+32'h004, 0, 32'h0,        32'h0,     0));
        vecs.push_back(mk(0, 32'h0,    1, 32'h22222222, 0, 1, 1, B+32'h008, 1, 32'h11111111, B+32'h000, 0));
        vecs.push_back(mk(0, 32'h0,    1, 32'h33333333, 0, 1, 1, B+32'h00C, 1, 32'h22222222, B+32'h004, 0));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,        0, 1, 1, B+32'h010, 1, 32'h33333333, B+32'h008, 0));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,        0, 1, 0, B+32'h014, 0, 32'h0,        32'h0,     0));
        vecs.push_back(mk(1, B+32'h100, 0, 32'h0,       0, 1, 0, B+32'h014, 0, 32'h0,        32'h0,     0));
        vecs.push_back(mk(0, 32'h0,    1, 32'hBAD0BAD0, 0, 1, 0, B+32'h100, 0, 32'h0,        32'h0,     0));
        vecs.push_back(mk(0, 32'h0,    1, 32'hBAD1BAD1, 0, 1, 1, B+32'h100, 0, 32'h0,        32'h0,     0));
        vecs.push_back(mk(0, 32'h0,    1, 32'h44444444, 0, 1, 1, B+32'h104, 0, 32'h0,        32'h0,     0));
        vecs.push_back(mk(0, 32'h0,    1, 32'h55555555, 0, 1, 1, B+32'h108, 1, 32'h44444444, B+32'h100, 0));
        vecs.push_back(mk(1, B+32'h200, 1, 32'h66666666, 0, 1, 0, B+32'h10C, 1, 32'h55555555, B+32'h104, 0));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,        0, 1, 1, B+32'h200, 0, 32'h0,        32'h0,     0));
        vecs.push_back(mk(0, 32'h0,    1, 32'h77777777, 0, 1, 1, B+32'h204, 0, 32'h0,        32'h0,     0));
        vecs.push_back(mk(1, B+32'h102, 1, 32'h88888888, 0, 0, 0, B+32'h208, 1, 32'h77777777, B+32'h200, 0));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,        0, 0, 0, B+32'h208, 1, 32'h0,        B+32'h102, 1));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,        0, 1, 0, B+32'h208, 1, 32'h0,        B+32'h102, 1));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,        0, 1, 0, B+32'h208, 0, 32'h0,        32'h0,     0));
        vecs.push_back(mk(1, B+32'h200, 0, 32'h0,       0, 1, 0, B+32'h208, 0, 32'h0,        32'h0,     0));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,        0, 1, 1, B+32'h200, 0, 32'h0,        32'h0,     0));
        vecs.push_back(mk(1, B,        1, 32'h99999999, 0, 1, 0, B+32'h204, 0, 32'h0,        32'h0,     0));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,        0, 1, 1, B+32'h000, 0, 32'h0,        32'h0,     0));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,        0, 1, 1, B+32'h004, 0, 32'h0,        32'h0,     0));
        vecs.push_back(mk(0, 32'h0,    1, 32'hAAAAAAAA, 0, 0, 0, B+32'h008, 0, 32'h0,        32'h0,     0));
        vecs.push_back(mk(0, 32'h0,    1, 32'hDEADBEEF, 1, 1, 1, B+32'h008, 1, 32'hAAAAAAAA, B+32'h000, 0));
        vecs.push_back(mk(0, 32'h0,    1, 32'hBBBBBBBB, 0, 0, 0, B+32'h00C, 1, 32'h0,        B+32'h004, 1));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,        0, 1, 0, B+32'h00C, 1, 32'h0,        B+32'h004, 1));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,        0, 1, 0, B+32'h00C, 0, 32'h0,        32'h0,     0));
        vecs.push_back(mk(1, B+32'h400, 0, 32'h0,       0, 1, 0, B+32'h00C, 0, 32'h0,        32'h0,     0));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,        0, 1, 1, B+32'h400, 0, 32'h0,        32'h0,     0));

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        #2;
        check_reset_values("reset");

        // Table: release reset at a negedge; row 0 is the first cycle out of reset.
        @(negedge clk);
        i_rst_n = 1'b1;
        for (int r = 0; r < vecs.size(); r++) begin
            i_redirect       = vecs[r].redir;
            i_redirect_pc    = vecs[r].rpc;
            i_ibus_rsp_valid = vecs[r].rsp_v;
            i_ibus_rsp_data  = vecs[r].rdata;
            i_ibus_rsp_err   = vecs[r].rerr;
            i_ir_ready       = vecs[r].irdy;
            i_ibus_req_ready = 1'b1;
            #2;
            chk($sformatf("row%0d_req_valid", r), {31'b0, o_ibus_req_valid}, {31'b0, vecs[r].e_rv});
            chk($sformatf("row%0d_req_addr", r), o_ibus_req_addr, vecs[r].e_ra);
            chk($sformatf("row%0d_ir_valid", r), {31'b0, o_ir_valid}, {31'b0, vecs[r].e_iv});
            if (vecs[r].e_iv) begin
                chk($sformatf("row%0d_ir_instr", r), o_ir_instr, vecs[r].e_ii);
                chk($sformatf("row%0d_ir_pc", r), o_ir_pc, vecs[r].e_ip);
                chk($sformatf("row%0d_ir_err", r), {31'b0, o_ir_err}, {31'b0, vecs[r].e_ie});
            end
            @(negedge clk);
        end

        // Decode backpressure on a 3-cycle bus.
        i_rst_n = 1'b0;
        i_redirect = 1'b0;
        i_ibus_rsp_valid = 1'b0;
        @(negedge clk);
        i_rst_n      = 1'b1;
        cyc          = 0;
        issued       = 0;
        popped       = 0;
        exp_pc       = B;
        exp_req      = B;
        stalled_prev = 1'b0;
        pend.delete();
        for (int c = 0; c < 40; c++) begin
            bus_step((c >= 8 && c < 14) ? 1'b0 : 1'b1, 3);
        end
        if (popped < 10) begin
            checks++;
            errors++;
            $display("FAIL bp_progress: popped %0d required at least 10", popped);
        end else begin
            checks++;
        end

        // Fill the FIFO with decode stalled, then reset asynchronously mid-cycle.
        for (int c = 0; c < 6; c++) begin
            bus_step(1'b0, 3);
        end
        #2;
        chk("pre_reset_ir_valid", {31'b0, o_ir_valid}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        pend.delete();
        i_ibus_rsp_valid = 1'b0;
        i_ir_ready       = 1'b1;
        @(negedge clk);
        i_rst_n = 1'b1;
        #1;
        chk("post_reset_req_valid", {31'b0, o_ibus_req_valid}, 32'd1);
        chk("post_reset_req_addr", o_ibus_req_addr, B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
